// File: rtl/cacheline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_mem_arbiter
// Brief    : Arbitrates I-cache and D-cache line fills / writebacks onto one
//            shared physical-memory port. One transaction at a time, with a
//            round-robin grant on simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // I-cache side
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    // D-cache side
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    // Physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;

    // last_grant encoding: 0 = I-cache was served last, 1 = D-cache
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;
    logic       w_next_last_grant;
    logic       w_i_req;
    logic       w_d_req;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // State and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= GRANT_I;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // Next-state: grant on IDLE exit, release on the memory response
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_i_req && w_d_req) begin
                    // Tie: serve whichever side did not win last time
                    if (r_last_grant == GRANT_I) begin
                        w_next_state      = S_SERVE_D;
                        w_next_last_grant = GRANT_D;
                    end else begin
                        w_next_state      = S_SERVE_I;
                        w_next_last_grant = GRANT_I;
                    end
                end else if (w_d_req) begin
                    w_next_state      = S_SERVE_D;
                    w_next_last_grant = GRANT_D;
                end else if (w_i_req) begin
                    w_next_state      = S_SERVE_I;
                    w_next_last_grant = GRANT_I;
                end
            end
            S_SERVE_I: begin
                if (pmem_resp) w_next_state = S_IDLE;
            end
            S_SERVE_D: begin
                if (pmem_resp) w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output steering: only the granted side is connected to memory
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_SERVE_I: begin
                busy         = 1'b1;
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_rdata = pmem_rdata;
                i_pmem_resp  = pmem_resp;
            end
            S_SERVE_D: begin
                busy         = 1'b1;
                // A simultaneous read+write resolves as writeback only
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_rdata = pmem_rdata;
                d_pmem_resp  = pmem_resp;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
